keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry_pkg.sv | 30 +++
 rtl/keypad_entry_sync2.sv | 23 ++
 rtl/keypad_entry.sv | 87 ++++++++
 tb/tb_keypad_entry.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_pkg.sv
// Shared types and constants for the microwave keypad time-entry block.
// Holds the FSM state enum, BCD digit type and key helper functions.
package keypad_entry_pkg;

  localparam int KEY_W        = 10;
  localparam int MAX_SEC_TENS = 5;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  function automatic logic is_onehot(input logic [KEY_W-1:0] k);
    return (k != '0) && ((k & (k - KEY_W'(1))) == '0);
  endfunction

  // Only meaningful for a one-hot vector; returns the digit of the set bit.
  function automatic bcd_t key_index(input logic [KEY_W-1:0] k);
    bcd_t idx;
    idx = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (k[i]) idx = bcd_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_entry_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Debounced keypad entry: shifts accepted digits into a min:ss BCD register
// and pulses load_strobe for the downstream cooking timer.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [KEY_W-1:0] keypad,
  input  logic             cooking,
  input  logic             clear_entry,
  output logic [3:0]       sec_ones,
  output logic [3:0]       sec_tens,
  output logic [3:0]       min,
  output logic             load_strobe,
  output logic             entry_valid
);

  logic [KEY_W-1:0] kp_s;
  logic [KEY_W-1:0] key_lat;
  logic [3:0]       deb_cnt;
  kp_state_t        state;

  sync2 #(.WIDTH(KEY_W)) u_sync (
    .clk  (clk),
    .clrn (clrn),
    .d    (keypad),
    .q    (kp_s)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      key_lat     <= '0;
      sec_ones    <= '0;
      sec_tens    <= '0;
      min         <= '0;
      load_strobe <= 1'b0;
    end else begin
      load_strobe <= 1'b0;
      if (clear_entry) begin
        // Clear wins over cooking lock and over a same-edge accept.
        sec_ones    <= '0;
        sec_tens    <= '0;
        min         <= '0;
        load_strobe <= 1'b1;
        state       <= IDLE;
      end else if (cooking) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (is_onehot(kp_s)) begin
              state   <= DEBOUNCE;
              key_lat <= kp_s;
              deb_cnt <= 4'd1;
            end
          end
          DEBOUNCE: begin
            if (kp_s != key_lat) begin
              state <= IDLE;
            end else if (deb_cnt == 4'(DEBOUNCE_CYCLES - 1)) begin
              min         <= sec_tens;
              sec_tens    <= sec_ones;
              sec_ones    <= key_index(key_lat);
              load_strobe <= 1'b1;
              state       <= HELD;
            end else begin
              deb_cnt <= deb_cnt + 4'd1;
            end
          end
          HELD: begin
            // No auto-repeat: wait for a full release before re-arming.
            if (kp_s == '0) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign entry_valid = (sec_tens <= bcd_t'(MAX_SEC_TENS)) &&
                       !((min == '0) && (sec_tens == '0) && (sec_ones == '0));

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: stimulus queues expected digit triples,
// a negedge monitor checks them against each load_strobe.
module tb_keypad_entry;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [9:0] keypad = '0;
  logic       cooking = 1'b0;
  logic       clear_entry = 1'b0;
  logic [3:0] sec_ones, sec_tens, min;
  logic       load_strobe, entry_valid;

  keypad_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .keypad      (keypad),
    .cooking     (cooking),
    .clear_entry (clear_entry),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min         (min),
    .load_strobe (load_strobe),
    .entry_valid (entry_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] mn;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_strobes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (clrn && load_strobe) begin
      n_strobes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: actual digits=%0d%0d:%0d required=no strobe",
                 min, sec_tens, sec_ones);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_digits", {min, sec_tens, sec_ones}, {e.mn, e.tens, e.ones});
        if (e.cyc >= 0) check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic expect_digits(input logic [3:0] mn, input logic [3:0] tens,
                               input logic [3:0] ones, input int at_cyc);
    exp_t e;
    e.ones = ones;
    e.tens = tens;
    e.mn   = mn;
    e.cyc  = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Press a key pattern for 'hold' cycles then release for 'rel' cycles.
  task automatic press(input logic [9:0] k, input int hold, input int rel);
    @(negedge clk);
    keypad = k;
    repeat (hold) @(negedge clk);
    keypad = '0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic check_outputs(input string name, input logic [3:0] mn,
                               input logic [3:0] tens, input logic [3:0] ones,
                               input logic ev);
    check({name, "_digits"}, {min, sec_tens, sec_ones}, {mn, tens, ones});
    check({name, "_entry_valid"}, entry_valid, ev);
  endtask

  initial begin
    #1;
    check_outputs("reset", 4'd0, 4'd0, 4'd0, 1'b0);
    check("reset_strobe", load_strobe, 0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // Key 3 held 20 cycles: E0 is the next posedge, strobe at E0+5.
    @(negedge clk);
    expect_digits(4'd0, 4'd0, 4'd3, cyc + 6);
    keypad = 10'b00_0000_1000;
    repeat (20) @(negedge clk);
    keypad = '0;
    repeat (5) @(negedge clk);
    wait_drain("key3", 10);
    check_outputs("key3", 4'd0, 4'd0, 4'd3, 1'b1);

    // Keys 1, 3, 0 then 5.
    expect_digits(4'd0, 4'd3, 4'd1, -1);
    press(10'b00_0000_0010, 10, 5);
    expect_digits(4'd3, 4'd1, 4'd3, -1);
    press(10'b00_0000_1000, 10, 5);
    expect_digits(4'd1, 4'd3, 4'd0, -1);
    press(10'b00_0000_0001, 10, 5);
    wait_drain("seq130", 10);
    check_outputs("seq130", 4'd1, 4'd3, 4'd0, 1'b1);
    expect_digits(4'd3, 4'd0, 4'd5, -1);
    press(10'b00_0010_0000, 10, 5);
    wait_drain("key5", 10);
    check_outputs("key5", 4'd3, 4'd0, 4'd5, 1'b1);

    // Bounce on key 7 and a two-key chord: both ignored.
    press(10'b00_1000_0000, 3, 10);
    press(10'b00_0001_0100, 20, 10);
    check_outputs("bounce_chord", 4'd3, 4'd0, 4'd5, 1'b1);

    // Keys 9, 0 give 5:90 which is not loadable; then clear.
    expect_digits(4'd0, 4'd5, 4'd9, -1);
    press(10'b10_0000_0000, 10, 5);
    expect_digits(4'd5, 4'd9, 4'd0, -1);
    press(10'b00_0000_0001, 10, 5);
    wait_drain("key90", 10);
    check_outputs("key90", 4'd5, 4'd9, 4'd0, 1'b0);
    expect_digits(4'd0, 4'd0, 4'd0, cyc + 1);
    clear_entry = 1'b1;
    @(negedge clk);
    clear_entry = 1'b0;
    repeat (3) @(negedge clk);
    wait_drain("clear", 5);
    check_outputs("clear", 4'd0, 4'd0, 4'd0, 1'b0);

    // Cooking lock with key 6 held, then release the lock with key still down.
    cooking = 1'b1;
    @(negedge clk);
    keypad = 10'b00_0100_0000;
    repeat (20) @(negedge clk);
    check_outputs("cooking", 4'd0, 4'd0, 4'd0, 1'b0);
    expect_digits(4'd0, 4'd0, 4'd6, -1);
    cooking = 1'b0;
    repeat (15) @(negedge clk);
    wait_drain("cook_release", 5);
    keypad = '0;
    repeat (5) @(negedge clk);
    check_outputs("cook_release", 4'd0, 4'd0, 4'd6, 1'b1);

    // Reset during the second debounce cycle of key 8, key held across release.
    @(negedge clk);
    keypad = 10'b01_0000_0000;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    #1;
    check_outputs("mid_reset", 4'd0, 4'd0, 4'd0, 1'b0);
    check("mid_reset_strobe", load_strobe, 0);
    repeat (2) @(negedge clk);
    expect_digits(4'd0, 4'd0, 4'd8, -1);
    clrn = 1'b1;
    repeat (25) @(negedge clk);
    wait_drain("key8_after_reset", 5);
    keypad = '0;
    repeat (5) @(negedge clk);
    check_outputs("key8_after_reset", 4'd0, 4'd0, 4'd8, 1'b1);

    check("total_strobes", n_strobes, 10);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
